// File: rtl/comparador_serial_ctrl_pkg.sv
// Shared constants for the serial magnitude comparator: FSM state encoding
// and the width of one comparator slice.
package comparador_serial_ctrl_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    COMPARA = 2'b01,
    FIM     = 2'b10
  } estado_t;

endpackage

// File: rtl/comparador_85.sv
// One 3-bit cascadable magnitude-comparator slice. The less/greater cascade
// pins carry swapped sense: ALBo reports "A greater so far", AGBo "A less so far".
module comparador_85
  import comparador_serial_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               alb_i,
  input  logic               agb_i,
  input  logic               aeb_i,
  output logic               alb_o,
  output logic               agb_o,
  output logic               aeb_o
);

  logic slice_eq;

  // Cascade inputs are active-low for the greater/less history.
  always_comb begin
    slice_eq = (a == b);
    alb_o    = (a > b) | (slice_eq & ~alb_i);
    agb_o    = (a < b) | (slice_eq & ~agb_i);
    aeb_o    = slice_eq & aeb_i;
  end

endmodule

// File: rtl/comparador_serial_ctrl.sv
// Compares two unsigned multi-slice operands LSB-first through one shared
// comparador_85 slice, one slice per clock, with a start/busy/done handshake.
module comparador_serial_ctrl
  import comparador_serial_ctrl_pkg::*;
#(
  parameter int SLICES = 4,
  parameter int IDX_W  = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iniciar,
  input  logic [SLICE_W*SLICES-1:0] A,
  input  logic [SLICE_W*SLICES-1:0] B,
  output logic                      ocupado,
  output logic                      pronto,
  output logic                      maior,
  output logic                      menor,
  output logic                      igual,
  output logic [IDX_W-1:0]          db_indice
);

  localparam int W = SLICE_W * SLICES;

  estado_t             state, state_next;
  logic [W-1:0]        ra, rb;
  logic [IDX_W-1:0]    indice;
  logic                gt_r, lt_r, eq_r;
  logic [SLICE_W-1:0]  slice_a, slice_b;
  logic                alb_o, agb_o, aeb_o;
  logic                accept, last;

  assign accept    = (state == OCIOSO) && iniciar;
  assign last      = (indice == IDX_W'(SLICES - 1));
  assign slice_a   = ra[SLICE_W*int'(indice) +: SLICE_W];
  assign slice_b   = rb[SLICE_W*int'(indice) +: SLICE_W];
  assign db_indice = indice;

  comparador_85 u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .alb_i (~gt_r),
    .agb_i (~lt_r),
    .aeb_i (eq_r),
    .alb_o (alb_o),
    .agb_o (agb_o),
    .aeb_o (aeb_o)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= OCIOSO;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      OCIOSO:  if (iniciar) state_next = COMPARA;
      COMPARA: if (last)    state_next = FIM;
      FIM:                  state_next = OCIOSO;
      default:              state_next = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = 1'b0;
    pronto  = 1'b0;
    case (state)
      COMPARA: ocupado = 1'b1;
      FIM: begin
        ocupado = 1'b1;
        pronto  = 1'b1;
      end
      default: ;
    endcase
  end

  // Operands are only meaningful after a start, so they carry no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      ra <= A;
      rb <= B;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      indice <= '0;
      gt_r   <= 1'b0;
      lt_r   <= 1'b0;
      eq_r   <= 1'b1;
      maior  <= 1'b0;
      menor  <= 1'b0;
      igual  <= 1'b0;
    end else if (accept) begin
      indice <= '0;
      gt_r   <= 1'b0;
      lt_r   <= 1'b0;
      eq_r   <= 1'b1;
    end else if (state == COMPARA) begin
      gt_r <= alb_o;
      lt_r <= agb_o;
      eq_r <= aeb_o;
      if (last) begin
        indice <= '0;
        maior  <= alb_o;
        menor  <= agb_o;
        igual  <= aeb_o;
      end else begin
        indice <= indice + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Directed bench for comparador_serial_ctrl with the default 4-slice, 12-bit configuration.
module tb_comparador_serial_ctrl;

  logic        clock;
  logic        reset;
  logic        iniciar;
  logic [11:0] A, B;
  logic        ocupado, pronto, maior, menor, igual;
  logic [1:0]  db_indice;

  int checks   = 0;
  int failures = 0;

  comparador_serial_ctrl #(.SLICES(4), .IDX_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .iniciar   (iniciar),
    .A         (A),
    .B         (B),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .maior     (maior),
    .menor     (menor),
    .igual     (igual),
    .db_indice (db_indice)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic g, input logic l, input logic e);
    check1({tag, "_maior"}, maior, g);
    check1({tag, "_menor"}, menor, l);
    check1({tag, "_igual"}, igual, e);
  endtask

  // Starts a compare and waits (bounded) for pronto; lat counts edges from the
  // start edge up to the cycle where pronto is high, busy counts ocupado cycles.
  task automatic do_compare(input logic [11:0] a, input logic [11:0] b,
                            output int lat, output int busy);
    A = a;
    B = b;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    lat  = 1;
    busy = ocupado ? 1 : 0;
    while (!pronto && lat < 20) begin
      step();
      lat++;
      if (ocupado) busy++;
    end
  endtask

  int lat, busy, cnt, np, last_p, extra;

  initial begin
    reset   = 1'b0;
    iniciar = 1'b0;
    A       = '0;
    B       = '0;
    #12;
    check1("rst_ocupado", ocupado, 1'b0);
    check1("rst_pronto", pronto, 1'b0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    checkn("rst_indice", int'(db_indice), 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    check1("idle_ocupado", ocupado, 1'b0);

    do_compare(12'h5A3, 12'h5A3, lat, busy);
    checkn("eq_latency", lat, 5);
    checkn("eq_busy", busy, 5);
    check1("eq_pronto", pronto, 1'b1);
    check_flags("eq", 1'b0, 1'b0, 1'b1);
    checkn("fim_indice", int'(db_indice), 0);
    step();
    check1("eq_pronto_drop", pronto, 1'b0);
    check1("eq_ocupado_drop", ocupado, 1'b0);
    check_flags("eq_hold", 1'b0, 1'b0, 1'b1);

    do_compare(12'h800, 12'h7FF, lat, busy);
    checkn("msb_latency", lat, 5);
    check_flags("msb", 1'b1, 1'b0, 1'b0);
    step();

    do_compare(12'h000, 12'h001, lat, busy);
    check_flags("lsb_lt", 1'b0, 1'b1, 1'b0);
    step();
    do_compare(12'h001, 12'h000, lat, busy);
    check_flags("lsb_gt", 1'b1, 1'b0, 1'b0);
    step();

    // Start request during COMPARA must be ignored.
    A = 12'h100;
    B = 12'h200;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    step();
    checkn("busy_indice", int'(db_indice), 1);
    A = 12'hFFF;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    cnt = 3;
    while (!pronto && cnt < 20) begin
      step();
      cnt++;
    end
    checkn("ign_latency", cnt, 5);
    check_flags("ign", 1'b0, 1'b1, 1'b0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pronto || ocupado) extra++;
    end
    checkn("ign_no_second", extra, 0);

    // Back-to-back with iniciar held high; B changes during the second compare.
    A = 12'h010;
    B = 12'h010;
    iniciar = 1'b1;
    np = 0;
    last_p = 0;
    for (cnt = 1; cnt <= 18; cnt++) begin
      step();
      if (cnt == 7) B = 12'h00F;
      if (cnt == 17) iniciar = 1'b0;
      if (pronto) begin
        np++;
        if (np == 1) begin
          checkn("b2b_first_at", cnt, 5);
          check_flags("b2b1", 1'b0, 1'b0, 1'b1);
        end else if (np == 2) begin
          checkn("b2b_gap2", cnt - last_p, 6);
          check_flags("b2b2", 1'b0, 1'b0, 1'b1);
        end else if (np == 3) begin
          checkn("b2b_gap3", cnt - last_p, 6);
          check_flags("b2b3", 1'b1, 1'b0, 1'b0);
        end
        last_p = cnt;
      end
    end
    checkn("b2b_count", np, 3);
    iniciar = 1'b0;
    step();
    step();

    // Asynchronous reset in the middle of a compare.
    A = 12'h0F0;
    B = 12'h0F0;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    step();
    step();
    checkn("mid_indice", int'(db_indice), 2);
    check1("mid_ocupado", ocupado, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check1("arst_ocupado", ocupado, 1'b0);
    check1("arst_pronto", pronto, 1'b0);
    check_flags("arst", 1'b0, 1'b0, 1'b0);
    checkn("arst_indice", int'(db_indice), 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    do_compare(12'h3FF, 12'h400, lat, busy);
    checkn("post_latency", lat, 5);
    check_flags("post", 1'b0, 1'b1, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparador_serial_ctrl.md
Name: comparador_serial_ctrl

Overview:
Sequencer that compares two multi-slice unsigned operands with a single 3-bit cascadable magnitude-comparator slice (comparador_85), one slice per clock. It processes slices LSB-first and feeds each slice's registered cascade result into the next. It uses a start/busy/done handshake and holds registered greater/less/equal flags for the surrounding datapath. It replaces a wide combinational comparator chain in the datapath with one shared slice.

Parameters:
SLICES, 4, number of 3-bit slices; operand width W = 3*SLICES (default 12); legal range 2..16
IDX_W, 2, width of slice index counter; must satisfy 2^IDX_W >= SLICES

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
iniciar  input  1  start request; sampled only in state OCIOSO
A  input  W  operand A, unsigned; captured on the accepted start edge
B  input  W  operand B, unsigned; captured on the accepted start edge
ocupado  output  1  high while state is COMPARA or FIM
pronto  output  1  one-cycle pulse; result flags valid and newly updated
maior  output  1  registered result A>B
menor  output  1  registered result A<B
igual  output  1  registered result A==B
db_indice  output  IDX_W  current slice index (debug)

Behaviour:
- Reset (reset=0, asynchronous): state=OCIOSO; ocupado=0, pronto=0, maior=0, menor=0, igual=0, db_indice=0; internal gt_r=0, lt_r=0, eq_r=1.
- The block has one clock domain. All outputs are registered or decoded directly from state.
- States: OCIOSO -> COMPARA -> FIM -> OCIOSO.
- OCIOSO: on an edge with iniciar=1:
  - capture A and B into ra and rb
  - set indice=0, gt_r=0, lt_r=0, eq_r=1
  - go to COMPARA
  - If iniciar=0, remain in OCIOSO.
- COMPARA: each edge consumes slice k = indice, i.e. bits [3k+2:3k] of ra and rb:
  - The slice is fed with ALBi=~gt_r, AGBi=~lt_r, AEBi=eq_r.
  - The registers update as gt_r<=ALBo, lt_r<=AGBo, eq_r<=AEBo. The slice's less/greater outputs carry swapped sense; this exact mapping is mandatory.
  - Resulting per-edge semantics: gt=(a_k>b_k) | (a_k==b_k & gt_prev); lt=(a_k<b_k) | (a_k==b_k & lt_prev); eq=(a_k==b_k) & eq_prev.
  - indice increments each edge.
  - On the edge processing k=SLICES-1: load maior/menor/igual from the slice outputs and go to FIM.
- FIM: pronto=1 for exactly this one cycle; next edge goes to OCIOSO.
- Latency: start accepted at edge E0; slices processed at E1..E_SLICES; pronto high in the cycle after E_SLICES. Default total is 5 cycles from start to done.
- Exactly one of maior/menor/igual is 1 after any completed compare. The flags hold until the next completion; a new start does not clear them.
- iniciar while in COMPARA or FIM is ignored, with no queuing. A new start is accepted in the first OCIOSO cycle after FIM, giving a minimum back-to-back period of SLICES+2 cycles.
- A and B changing during COMPARA have no effect, because the operands are captured.
- Reset mid-operation aborts immediately to reset values; the previous result flags are cleared.
- db_indice reflects indice. It is 0 in OCIOSO and FIM.

Decomposition:
- Shared package/include: state encodings (OCIOSO=2'b00, COMPARA=2'b01, FIM=2'b10) and the slice width constant SLICE_W=3.
- One sub-module: a single comparador_85 instance as the slice datapath.
- The FSM, index counter, operand and cascade registers, and result registers stay in comparador_serial_ctrl.

Test Plan:
- Equal operands: SLICES=4, A=12'h5A3, B=12'h5A3, pulse iniciar -> pronto 5 cycles after start edge; igual=1, maior=0, menor=0; ocupado high for exactly 5 cycles.
- MSB slice decides: A=12'h800, B=12'h7FF -> maior=1, menor=0, igual=0, although the LSB slice gives A<B.
- LSB-only difference: A=12'h000, B=12'h001 -> menor=1. Then A=12'h001, B=12'h000 -> maior=1.
- Start ignored while busy: start A=12'h100, B=12'h200; pulse iniciar with A=12'hFFF at cycle 2 -> single pronto, menor=1; no second compare begins.
- Back-to-back operation:
  - Hold iniciar=1 continuously, A=12'h010, B=12'h010 -> compare accepted every 6 cycles; pronto pulses 6 cycles apart; igual=1 each time.
  - Change B to 12'h00F while ocupado -> that result is unaffected; the next result is maior=1.
- Reset mid-compare: assert reset=0 asynchronously during COMPARA (db_indice=2) -> all outputs 0 immediately, state OCIOSO. After release, a new compare of A=12'h3FF, B=12'h400 gives menor=1.
